// File: rtl/subneg_membus_ctrl_if.sv
// Request/response and external multiplexed-bus signals of the SUBNEG memory sequencer.
// The slave modport is the sequencer side; the master modport is the core/board side.
interface subneg_membus_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic [7:0] bus_oe;
    logic       le;
    logic       moe;
    logic       mwe;
    logic [3:0] dbg_state;

    // Handshake: a request is taken on a clk edge where req_valid & req_ready;
    // req_* are sampled only then. rsp_valid is a single-cycle completion pulse.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bus_in,
        output req_ready, rsp_valid, rsp_rdata, bus_out, bus_oe, le, moe, mwe, dbg_state
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bus_in,
        input  req_ready, rsp_valid, rsp_rdata, bus_out, bus_oe, le, moe, mwe, dbg_state
    );
endinterface

// File: rtl/subneg_membus_ctrl.sv
// Byte-wide multiplexed external-memory bus sequencer for the SUBNEG core.
// Optional MEMBUS_DISPLAY_EN maps DISPLAY_ADDR onto an internal display register.
module subneg_membus_ctrl #(
    parameter int         SETUP_CYCLES = 1,
    parameter int         READ_WAIT    = 1,
    parameter int         WRITE_PULSE  = 1,
    parameter logic [7:0] DISPLAY_ADDR = 8'd21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    subneg_membus_ctrl_if.slave  mb
`ifdef MEMBUS_DISPLAY_EN
    ,
    output logic [7:0]           display_out
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_HOLD, S_TURN, S_RD, S_WDATA, S_WR, S_RECOV, S_DONE
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] RD_LD    = 4'(READ_WAIT);
    localparam logic [3:0] WR_LD    = 4'(WRITE_PULSE - 1);

`ifdef MEMBUS_DISPLAY_EN
    localparam bit DISPLAY_EN = 1'b1;
`else
    localparam bit DISPLAY_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic       we_q;
    logic [7:0] addr_q, wdata_q;
    logic       accept, disp_hit;
    logic [7:0] addr_d, wdata_d;

    logic       le_d, moe_d, mwe_d, rsp_valid_d;
    logic [7:0] bus_out_d, bus_oe_d;

    assign accept       = mb.req_valid && (state_q == S_IDLE);
    assign disp_hit     = DISPLAY_EN && accept && (mb.req_addr == DISPLAY_ADDR);
    assign mb.req_ready = (state_q == S_IDLE);
    assign mb.dbg_state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = disp_hit ? S_DONE : S_ADDR;
            S_ADDR:  if (cnt_q == 4'd0) state_d = S_HOLD;
            S_HOLD:  state_d = we_q ? S_WDATA : S_TURN;
            S_TURN:  state_d = S_RD;
            S_RD:    if (cnt_q == 4'd0) state_d = S_DONE;
            S_WDATA: state_d = S_WR;
            S_WR:    if (cnt_q == 4'd0) state_d = S_RECOV;
            S_RECOV: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    assign addr_d  = accept ? mb.req_addr  : addr_q;
    assign wdata_d = accept ? mb.req_wdata : wdata_q;

    always_comb begin
        le_d        = 1'b0;
        moe_d       = 1'b0;
        mwe_d       = 1'b0;
        rsp_valid_d = 1'b0;
        bus_out_d   = 8'h00;
        bus_oe_d    = 8'h00;
        case (state_d)
            S_ADDR: begin
                le_d      = 1'b1;
                bus_out_d = addr_d;
                bus_oe_d  = 8'hFF;
            end
            S_HOLD: begin
                bus_out_d = addr_d;
                bus_oe_d  = 8'hFF;
            end
            S_RD:    moe_d = 1'b1;
            S_WDATA, S_RECOV: begin
                bus_out_d = wdata_d;
                bus_oe_d  = 8'hFF;
            end
            S_WR: begin
                mwe_d     = 1'b1;
                bus_out_d = wdata_d;
                bus_oe_d  = 8'hFF;
            end
            S_DONE:  rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb.le        <= 1'b0;
            mb.moe       <= 1'b0;
            mb.mwe       <= 1'b0;
            mb.rsp_valid <= 1'b0;
            mb.bus_out   <= 8'h00;
            mb.bus_oe    <= 8'h00;
        end else begin
            mb.le        <= le_d;
            mb.moe       <= moe_d;
            mb.mwe       <= mwe_d;
            mb.rsp_valid <= rsp_valid_d;
            mb.bus_out   <= bus_out_d;
            mb.bus_oe    <= bus_oe_d;
        end
    end

    // Request latch and phase counter; the counter is loaded on entry to a timed phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            if (accept) begin
                we_q    <= mb.req_we;
                addr_q  <= mb.req_addr;
                wdata_q <= mb.req_wdata;
            end
            if (state_d != state_q) begin
                case (state_d)
                    S_ADDR:  cnt_q <= SETUP_LD;
                    S_RD:    cnt_q <= RD_LD;
                    S_WR:    cnt_q <= WR_LD;
                    default: cnt_q <= 4'd0;
                endcase
            end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

`ifdef MEMBUS_DISPLAY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_out  <= 8'h00;
            mb.rsp_rdata <= 8'h00;
        end else begin
            if (disp_hit && mb.req_we)
                display_out <= mb.req_wdata;
            if (disp_hit && !mb.req_we)
                mb.rsp_rdata <= display_out;
            else if (state_q == S_RD && cnt_q == 4'd0)
                mb.rsp_rdata <= mb.bus_in;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mb.rsp_rdata <= 8'h00;
        else if (state_q == S_RD && cnt_q == 4'd0)
            mb.rsp_rdata <= mb.bus_in;
    end
`endif

endmodule

// File: tb/tb_subneg_membus_ctrl.sv
// Bench for subneg_membus_ctrl: transaction-schedule model checked every cycle,
// plus directed read/write/back-to-back/reset/display scenarios with literal expectations.
module tb_subneg_membus_ctrl;
  localparam int         SETUP_CYCLES = 1;
  localparam int         READ_WAIT    = 1;
  localparam int         WRITE_PULSE  = 1;
  localparam logic [7:0] DISPLAY_ADDR = 8'd21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  subneg_membus_ctrl_if mb();
`ifdef MEMBUS_DISPLAY_EN
  logic [7:0] display_out;
`endif

  subneg_membus_ctrl #(
    .SETUP_CYCLES(SETUP_CYCLES),
    .READ_WAIT(READ_WAIT),
    .WRITE_PULSE(WRITE_PULSE),
    .DISPLAY_ADDR(DISPLAY_ADDR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mb(mb)
`ifdef MEMBUS_DISPLAY_EN
    ,
    .display_out(display_out)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each entry is the expected output set of one cycle after an accept:
  // {rsp_valid, bus_out, bus_oe, le, moe, mwe, capture-bus_in-at-end-of-cycle}
  logic [20:0] exp_q[$];
  logic [7:0]  m_rdata = 8'h00;
  logic [7:0]  m_disp = 8'h00;

  function automatic logic [20:0] mk(input logic rv, input logic [7:0] bo, input logic [7:0] oe,
                                     input logic le, input logic moe, input logic mwe, input logic cap);
    return {rv, bo, oe, le, moe, mwe, cap};
  endfunction

  task automatic push_txn(input bit we, input logic [7:0] a, input logic [7:0] d);
`ifdef MEMBUS_DISPLAY_EN
    if (a == DISPLAY_ADDR) begin
      if (we) m_disp = d;
      else    m_rdata = m_disp;
      exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0));
      return;
    end
`endif
    for (int i = 0; i < SETUP_CYCLES; i++) exp_q.push_back(mk(0, a, 8'hFF, 1, 0, 0, 0));
    exp_q.push_back(mk(0, a, 8'hFF, 0, 0, 0, 0));
    if (!we) begin
      exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0));
      for (int i = 0; i <= READ_WAIT; i++) exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, i == READ_WAIT));
    end else begin
      exp_q.push_back(mk(0, d, 8'hFF, 0, 0, 0, 0));
      for (int i = 0; i < WRITE_PULSE; i++) exp_q.push_back(mk(0, d, 8'hFF, 0, 0, 1, 0));
      exp_q.push_back(mk(0, d, 8'hFF, 0, 0, 0, 0));
    end
    exp_q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0));
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [20:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_rdata = 8'h00;
      m_disp = 8'h00;
    end else if (exp_q.size() == 0) begin
      if (mb.req_valid) push_txn(mb.req_we, mb.req_addr, mb.req_wdata);
    end else begin
      e = exp_q.pop_front();
      if (e[0]) m_rdata = mb.bus_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [20:0] e, a;
    if (rst_n) begin
      e = (exp_q.size() != 0) ? exp_q[0] : mk(0, 8'h00, 8'h00, 0, 0, 0, 0);
      a = {mb.rsp_valid, (e[11:4] == 8'hFF) ? mb.bus_out : 8'h00, mb.bus_oe, mb.le, mb.moe, mb.mwe, e[0]};
      check(a == e, "cycle_outputs", 32'(a), 32'(e));
      check(mb.req_ready == (exp_q.size() == 0), "req_ready", 32'(mb.req_ready), 32'(exp_q.size() == 0));
      check(mb.rsp_rdata == m_rdata, "rsp_rdata", 32'(mb.rsp_rdata), 32'(m_rdata));
      check(!(mb.moe && mb.mwe), "moe_mwe_excl", {mb.moe, mb.mwe}, 32'h0);
      check(!mb.moe || mb.bus_oe == 8'h00, "moe_oe", 32'(mb.bus_oe), 32'h00);
      check(!mb.mwe || mb.bus_oe == 8'hFF, "mwe_oe", 32'(mb.bus_oe), 32'hFF);
`ifdef MEMBUS_DISPLAY_EN
      check(display_out == m_disp, "display_out", 32'(display_out), 32'(m_disp));
`endif
    end
  end

  // ---------------- driver ----------------
  bit rand_bus = 1'b0;
  always @(negedge clk) if (rand_bus) mb.bus_in = 8'($urandom);

  int w_rsp, w_le, w_moe, w_mwe;
  logic [7:0] w_le_addr, w_le_oe, w_mwe_data, w_mwe_oe, w_rdata;
  bit w_gap_bad, w_after_ok, w_oe_any;

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (mb.req_ready) return;
      @(negedge clk);
    end
    check(0, "ready_timeout", 32'(mb.req_ready), 32'h1);
  endtask

  // Issue one request at a negedge and observe cycles 1..n after the accept edge.
  task automatic run(input bit we, input logic [7:0] a, input logic [7:0] d, input int n);
    logic prev_moe, prev_mwe;
    logic [7:0] prev_oe;
    @(negedge clk);
    wait_ready();
    rand_bus = 1'b0;
    mb.bus_in = we ? 8'h00 : d;
    mb.req_valid = 1'b1;
    mb.req_we = we;
    mb.req_addr = a;
    mb.req_wdata = d;
    w_rsp = 0; w_le = 0; w_moe = 0; w_mwe = 0;
    w_le_addr = 0; w_le_oe = 0; w_mwe_data = 0; w_mwe_oe = 0; w_rdata = 0;
    w_gap_bad = 0; w_after_ok = 0; w_oe_any = 0;
    prev_moe = mb.moe; prev_mwe = mb.mwe; prev_oe = mb.bus_oe;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mb.req_valid = 1'b0;
        mb.req_addr = ~a;
        mb.req_wdata = ~d;
        mb.req_we = ~we;
      end
      if (mb.rsp_valid && w_rsp == 0) begin w_rsp = k; w_rdata = mb.rsp_rdata; end
      if (mb.le) begin w_le++; w_le_addr = mb.bus_out; w_le_oe = mb.bus_oe; end
      if (mb.moe) begin w_moe++; if (!prev_moe && prev_oe != 8'h00) w_gap_bad = 1; end
      if (mb.mwe) begin w_mwe++; w_mwe_data = mb.bus_out; w_mwe_oe = mb.bus_oe; end
      if (prev_mwe && !mb.mwe) w_after_ok = (mb.bus_oe == 8'hFF && mb.bus_out == d);
      if (mb.bus_oe != 8'h00) w_oe_any = 1;
      prev_moe = mb.moe; prev_mwe = mb.mwe; prev_oe = mb.bus_oe;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check(mb.le == 0 && mb.moe == 0 && mb.mwe == 0, {tag, "_strobes"}, {mb.le, mb.moe, mb.mwe}, 32'h0);
    check(mb.bus_oe == 8'h00, {tag, "_bus_oe"}, 32'(mb.bus_oe), 32'h00);
    check(mb.bus_out == 8'h00, {tag, "_bus_out"}, 32'(mb.bus_out), 32'h00);
    check(mb.rsp_valid == 0, {tag, "_rsp_valid"}, 32'(mb.rsp_valid), 32'h0);
    check(mb.rsp_rdata == 8'h00, {tag, "_rsp_rdata"}, 32'(mb.rsp_rdata), 32'h00);
`ifdef MEMBUS_DISPLAY_EN
    check(display_out == 8'h00, {tag, "_display"}, 32'(display_out), 32'h00);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc[$];
    int rsp_seen;
    mb.req_valid = 1'b0;
    mb.req_we = 1'b0;
    mb.req_addr = 8'h00;
    mb.req_wdata = 8'h00;
    mb.bus_in = 8'h00;

    #12;
    check_reset_values("reset_hold");
    @(negedge clk); #2 rst_n = 1'b1;
    #1 check(mb.req_ready == 1, "ready_after_reset", 32'(mb.req_ready), 32'h1);

    // read 0x10, memory returns 0x5A
    run(0, 8'h10, 8'h5A, 8);
    check(w_rsp == 6, "rd_rsp_cycle", 32'(w_rsp), 32'd6);
    check(w_rdata == 8'h5A, "rd_data", 32'(w_rdata), 32'h5A);
    check(w_le == 1 && w_le_addr == 8'h10 && w_le_oe == 8'hFF, "rd_le_phase", {w_le[7:0], w_le_addr, w_le_oe}, 32'h0110FF);
    check(w_moe == 2, "rd_moe_len", 32'(w_moe), 32'd2);
    check(!w_gap_bad, "rd_turnaround", 32'(w_gap_bad), 32'h0);
    check(w_mwe == 0, "rd_no_mwe", 32'(w_mwe), 32'd0);

    // write 0xC3 to 0x20
    run(1, 8'h20, 8'hC3, 8);
    check(w_rsp == 6, "wr_rsp_cycle", 32'(w_rsp), 32'd6);
    check(w_mwe == 1 && w_mwe_data == 8'hC3 && w_mwe_oe == 8'hFF, "wr_pulse", {w_mwe[7:0], w_mwe_data, w_mwe_oe}, 32'h01C3FF);
    check(w_after_ok, "wr_recovery_drive", 32'(w_after_ok), 32'h1);
    check(w_moe == 0, "wr_no_moe", 32'(w_moe), 32'd0);
    check(w_rdata == 8'h5A, "wr_keeps_rdata", 32'(w_rdata), 32'h5A);

    // back-to-back reads, address scrambled every cycle
    @(negedge clk);
    wait_ready();
    rand_bus = 1'b1;
    mb.req_valid = 1'b1;
    mb.req_we = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k != 0) @(negedge clk);
      if (mb.req_valid && mb.req_ready) acc.push_back(k);
      mb.req_addr = 8'($urandom);
    end
    mb.req_valid = 1'b0;
    check(acc.size() == 5, "b2b_accepts", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++)
      check(acc[i] - acc[i-1] == 7, "b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd7);

    // reset during the RD phase
    run(0, 8'h44, 8'hE1, 4);
    check(mb.moe == 1, "rst_pre_moe", 32'(mb.moe), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    check(mb.req_ready == 1, "rst_mid_ready", 32'(mb.req_ready), 32'h1);
    @(negedge clk); #2 rst_n = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mb.rsp_valid) rsp_seen++;
    end
    check(rsp_seen == 0, "rst_dropped_rsp", 32'(rsp_seen), 32'd0);
    run(0, 8'h33, 8'h9C, 8);
    check(w_rsp == 6 && w_rdata == 8'h9C, "post_rst_read", {w_rsp[7:0], w_rdata}, 32'h069C);

    // display address
    run(1, DISPLAY_ADDR, 8'h7E, 8);
`ifdef MEMBUS_DISPLAY_EN
    check(w_rsp == 1, "disp_rsp_cycle", 32'(w_rsp), 32'd1);
    check(display_out == 8'h7E, "disp_value", 32'(display_out), 32'h7E);
    check(w_le == 0 && w_mwe == 0 && !w_oe_any, "disp_no_bus", {w_le[7:0], w_mwe[7:0], 7'h0, w_oe_any}, 32'h0);
    run(0, DISPLAY_ADDR, 8'h00, 4);
    check(w_rsp == 1 && w_rdata == 8'h7E, "disp_read", {w_rsp[7:0], w_rdata}, 32'h017E);
`else
    check(w_rsp == 6, "disp_addr_bus_rsp", 32'(w_rsp), 32'd6);
    check(w_mwe == 1 && w_mwe_data == 8'h7E, "disp_addr_bus_write", {w_mwe[7:0], w_mwe_data}, 32'h017E);
`endif

    // randomized traffic
    rand_bus = 1'b1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      mb.req_valid = ($urandom_range(0, 3) != 0);
      mb.req_we = 1'($urandom);
      mb.req_addr = ($urandom_range(0, 7) == 0) ? DISPLAY_ADDR : 8'($urandom);
      mb.req_wdata = 8'($urandom);
    end
    mb.req_valid = 1'b0;
    repeat (12) @(negedge clk);
    check(mb.req_ready == 1, "final_idle", 32'(mb.req_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
